// File: rtl/pipelined_datapath.sv
// Three-stage (ID/EX/WB) datapath with a valid/ready instruction handshake, load handshake and RAW handling.
// Define PIPELINED_DATAPATH_FORWARDING_EN to forward the EX result to ID instead of stalling on EX hazards.
module pipelined_datapath #(
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter int unsigned DATABUS_SIZE      = 32,
  parameter int unsigned REGFILE_ADDR_BITS = 5,
  parameter int unsigned OPCODE_SIZE       = 4,
  parameter int unsigned IMMEDIATE_WIDTH   = INSTRUCTION_WIDTH - OPCODE_SIZE - 3*REGFILE_ADDR_BITS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  input  logic [DATABUS_SIZE-1:0]      load_data,
  input  logic                         load_valid,
  output logic                         wb_valid,
  output logic [REGFILE_ADDR_BITS-1:0] wb_addr,
  output logic [DATABUS_SIZE-1:0]      wb_data,
  output logic [3:0]                   alu_flags,
  input  logic [REGFILE_ADDR_BITS-1:0] dbg_addr,
  output logic [DATABUS_SIZE-1:0]      dbg_data
);

  localparam int unsigned DW    = DATABUS_SIZE;
  localparam int unsigned AW    = REGFILE_ADDR_BITS;
  localparam int unsigned OW    = OPCODE_SIZE;
  localparam int unsigned DEPTH = 2**REGFILE_ADDR_BITS;

  localparam logic [OW-1:0] OP_ADD  = OW'(0);
  localparam logic [OW-1:0] OP_SUB  = OW'(1);
  localparam logic [OW-1:0] OP_AND  = OW'(2);
  localparam logic [OW-1:0] OP_OR   = OW'(3);
  localparam logic [OW-1:0] OP_XOR  = OW'(4);
  localparam logic [OW-1:0] OP_ADDI = OW'(5);
  localparam logic [OW-1:0] OP_LOAD = OW'(6);

  logic [DW-1:0] regs [DEPTH];

  // ID: field extraction
  logic [OW-1:0]              id_op;
  logic [AW-1:0]              id_rd, id_r1, id_r2;
  logic [IMMEDIATE_WIDTH-1:0] id_imm;
  logic                       id_use_r1, id_use_r2;

  assign id_op     = instruction[INSTRUCTION_WIDTH-1 -: OW];
  assign id_rd     = instruction[INSTRUCTION_WIDTH-OW-1 -: AW];
  assign id_r1     = instruction[INSTRUCTION_WIDTH-OW-AW-1 -: AW];
  assign id_r2     = instruction[INSTRUCTION_WIDTH-OW-2*AW-1 -: AW];
  assign id_imm    = instruction[IMMEDIATE_WIDTH-1:0];
  assign id_use_r1 = (id_op <= OP_ADDI);
  assign id_use_r2 = (id_op <= OP_XOR);

  // EX stage state
  logic          ex_valid;
  logic [OW-1:0] ex_op;
  logic [AW-1:0] ex_rd;
  logic [DW-1:0] ex_a, ex_b;
  logic          ex_writes, ex_is_load, ex_hold;

  assign ex_writes  = ex_valid && (ex_op <= OP_LOAD);
  assign ex_is_load = ex_valid && (ex_op == OP_LOAD);
  assign ex_hold    = ex_is_load && !load_valid;

  // EX: ALU
  logic [DW:0]   sum, diff;
  logic [DW-1:0] alu_res, ex_result;
  logic          alu_c, alu_v, flags_upd;

  always_comb begin
    sum     = {1'b0, ex_a} + {1'b0, ex_b};
    diff    = {1'b0, ex_a} - {1'b0, ex_b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ex_op)
      OP_ADD, OP_ADDI: begin
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
        alu_v   = (ex_a[DW-1] == ex_b[DW-1]) && (alu_res[DW-1] != ex_a[DW-1]);
      end
      OP_SUB: begin
        alu_res = diff[DW-1:0];
        alu_c   = !diff[DW];
        alu_v   = (ex_a[DW-1] != ex_b[DW-1]) && (alu_res[DW-1] != ex_a[DW-1]);
      end
      OP_AND:  alu_res = ex_a & ex_b;
      OP_OR:   alu_res = ex_a | ex_b;
      OP_XOR:  alu_res = ex_a ^ ex_b;
      default: alu_res = '0;
    endcase
  end

  assign ex_result = ex_is_load ? load_data : alu_res;
  assign flags_upd = ex_valid && (ex_op <= OP_ADDI);

  // ID operand read: r0 is zero, optional EX forward, then write-first bypass of the WB write
  logic [DW-1:0] rd_a, rd_b, id_b;

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (id_r1 == '0)
      rd_a = '0;
`ifdef PIPELINED_DATAPATH_FORWARDING_EN
    else if (ex_writes && ex_rd == id_r1)
      rd_a = ex_result;
`endif
    else if (wb_valid && wb_addr == id_r1)
      rd_a = wb_data;
    else
      rd_a = regs[id_r1];

    if (id_r2 == '0)
      rd_b = '0;
`ifdef PIPELINED_DATAPATH_FORWARDING_EN
    else if (ex_writes && ex_rd == id_r2)
      rd_b = ex_result;
`endif
    else if (wb_valid && wb_addr == id_r2)
      rd_b = wb_data;
    else
      rd_b = regs[id_r2];
  end

  assign id_b = (id_op == OP_ADDI) ? DW'(id_imm) : rd_b;

`ifdef PIPELINED_DATAPATH_FORWARDING_EN
  assign in_ready = !reset && !ex_hold;
`else
  logic raw;
  assign raw = in_valid && ex_writes &&
               ((id_use_r1 && id_r1 != '0 && id_r1 == ex_rd) ||
                (id_use_r2 && id_r2 != '0 && id_r2 == ex_rd));
  assign in_ready = !reset && !ex_hold && !raw;
`endif

  logic accept;
  assign accept   = in_valid && in_ready;
  assign dbg_data = regs[dbg_addr];

  // Pipeline registers, flags and register file
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      ex_op     <= '0;
      ex_rd     <= '0;
      ex_a      <= '0;
      ex_b      <= '0;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      alu_flags <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wb_valid && wb_addr != '0) regs[wb_addr] <= wb_data;

      if (ex_hold) begin
        wb_valid <= 1'b0;
      end else begin
        wb_valid <= ex_writes;
        wb_addr  <= ex_rd;
        wb_data  <= ex_result;
        ex_valid <= accept;
        if (accept) begin
          ex_op <= id_op;
          ex_rd <= id_rd;
          ex_a  <= id_use_r1 ? rd_a : '0;
          ex_b  <= id_b;
        end
      end

      if (flags_upd) alu_flags <= {alu_res[DW-1], alu_res == '0, alu_c, alu_v};
    end
  end

endmodule
